// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: FIFO-buffered, fixed-rate sample pacer feeding a delta-sigma DAC.
// Define DAC_FEEDER_INTERP_EN for a linear ramp between samples; otherwise zero-order hold.
module dac_sample_feeder #(
   parameter int CLKS_PER_SAMPLE = 2048,
   parameter int DEPTH = 4,
   parameter int INTERP_LOG2 = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic [15:0] s_data,
   input  logic s_valid,
   output logic s_ready,
   output logic sample_tick,
   output logic [15:0] sample_out,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CLKS_PER_SAMPLE);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_SAMPLE - 1);

   if (CLKS_PER_SAMPLE < 4) begin : g_bad_cps
      $error("CLKS_PER_SAMPLE must be at least 4");
   end
   if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of 2, at least 2");
   end
   if ((1 << INTERP_LOG2) > CLKS_PER_SAMPLE - 1) begin : g_bad_interp
      $error("ramp length must fit inside one sample period");
   end

   logic [15:0] mem_q [DEPTH];
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] prev_q, prev_d, target_q, target_d, out_q, out_d;
   logic push, pop, full, empty;

   always_comb begin
      sample_tick = cnt_q == CNT_LAST;
      fifo_level = wr_q - rd_q;
      full = fifo_level == (AW+1)'(DEPTH);
      empty = wr_q == rd_q;
      s_ready = !full;
      push = s_valid && s_ready;
      pop = sample_tick && !empty;
      underflow = sample_tick && empty;
      cnt_d = sample_tick ? '0 : cnt_q + CW'(1);
      wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
      rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
      prev_d = sample_tick ? target_q : prev_q;
      target_d = pop ? mem_q[rd_q[AW-1:0]] : target_q;
   end

`ifdef DAC_FEEDER_INTERP_EN
   localparam int PW = INTERP_LOG2 + 1;
   localparam int MW = PW + 18;
   localparam logic [PW-1:0] PH_MAX = PW'(1 << INTERP_LOG2);
   logic [PW-1:0] phase;
   logic signed [16:0] delta;
   logic signed [MW-1:0] step;
   // Floored step keeps the result between prev and target, so 16-bit wrap is safe.
   always_comb begin
      phase = (int'(cnt_q) >= (1 << INTERP_LOG2)) ? PH_MAX : PW'(cnt_q);
      delta = $signed({target_q[15], target_q}) - $signed({prev_q[15], prev_q});
      step = (MW'(delta) * MW'($signed({1'b0, phase}))) >>> INTERP_LOG2;
      out_d = prev_q + step[15:0];
   end
`else
   always_comb out_d = target_q;
`endif

   assign sample_out = out_q;

   always_ff @(posedge clk)
      if (push) mem_q[wr_q[AW-1:0]] <= s_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         prev_q <= '0;
         target_q <= '0;
         out_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         prev_q <= prev_d;
         target_q <= target_d;
         out_q <= out_d;
      end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed stimulus with a queue scoreboard checking every cycle.
module tb_dac_sample_feeder;
   localparam int CPS = 16;
   logic clk = 0, rst = 1, s_valid = 0;
   logic s_ready, sample_tick, underflow;
   logic [15:0] s_data = 0, sample_out;
   logic [2:0] fifo_level;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   dac_sample_feeder #(.CLKS_PER_SAMPLE(CPS), .DEPTH(4), .INTERP_LOG2(2)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .sample_tick(sample_tick), .sample_out(sample_out), .fifo_level(fifo_level),
      .underflow(underflow)
   );

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int ramp(input int p, input int t, input int ph);
      int num, r;
      num = (t - p) * ph;
      r = num / 4;
      if (num < 0 && num % 4 != 0) r -= 1;
      return p + r;
   endfunction

   // Scoreboard: accepted samples queue up; each model tick pops the expected target.
   int q[$];
   int m_cnt, m_prev, m_tgt, m_out, nxt;
   bit tick, acc;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         q.delete();
         m_cnt = 0; m_prev = 0; m_tgt = 0; m_out = 0;
      end else begin
         tick = m_cnt == CPS - 1;
         acc = s_valid && q.size() < 4;
         check("sb_out", $signed(sample_out), m_out);
         check("sb_level", int'(fifo_level), q.size());
         check("sb_ready", int'(s_ready), int'(q.size() < 4));
         check("sb_tick", int'(sample_tick), int'(tick));
         check("sb_underflow", int'(underflow), int'(tick && q.size() == 0));
`ifdef DAC_FEEDER_INTERP_EN
         nxt = ramp(m_prev, m_tgt, m_cnt < 4 ? m_cnt : 4);
`else
         nxt = m_tgt;
`endif
         if (tick) begin
            m_prev = m_tgt;
            if (q.size() > 0) m_tgt = q.pop_front();
         end
         if (acc) q.push_back(int'($signed(s_data)));
         m_cnt = tick ? 0 : m_cnt + 1;
         m_out = nxt;
      end
   end

   task automatic tick_wait(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (!sample_tick && n < 40);
      total++;
      if (!sample_tick) begin
         bad++;
         $display("FAIL %s: sample_tick=0 after %0d cycles, want 1", nm, n);
      end
   endtask

   task automatic push(input int v);
      int n = 0;
      @(posedge clk); #1;
      s_valid = 1; s_data = 16'(v);
      do begin @(negedge clk); n++; end while (!s_ready && n < 40);
      check($sformatf("push_%0d_ready", v), int'(s_ready), 1);
      @(posedge clk); #1;
      s_valid = 0;
   endtask

   task automatic chk_seq(input string nm, input int e[7]);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check($sformatf("%s[%0d]", nm, i), $signed(sample_out), e[i]);
      end
   endtask

   task automatic chk_reset(input string nm);
      check({nm, "_out"}, int'(sample_out), 0);
      check({nm, "_level"}, int'(fifo_level), 0);
      check({nm, "_ready"}, int'(s_ready), 1);
      check({nm, "_underflow"}, int'(underflow), 0);
   endtask

   initial begin
      int e[7];
      int ufs, nz, a, accs;
      #2 chk_reset("t1_rst");
      repeat (2) @(posedge clk);
      #1 rst = 0;
      ufs = 0; nz = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         ufs += int'(underflow);
         nz += int'(sample_out != 0);
      end
      check("t1_underflows", ufs, 3);
      check("t1_out_nonzero", nz, 0);

      push(400);
      tick_wait("t2_tick");
`ifdef DAC_FEEDER_INTERP_EN
      e = '{0, 0, 100, 200, 300, 400, 400};
`else
      e = '{0, 400, 400, 400, 400, 400, 400};
`endif
      chk_seq("t2_ramp", e);
      tick_wait("t2_hold_tick");
      check("t2_hold", $signed(sample_out), 400);

      push(0); push(-3); push(-32768); push(32767);
      tick_wait("t3_tick_a");
      tick_wait("t3_tick_b");
`ifdef DAC_FEEDER_INTERP_EN
      e = '{0, 0, -1, -2, -3, -3, -3};
`else
      e = '{0, -3, -3, -3, -3, -3, -3};
`endif
      chk_seq("t3_neg", e);
      tick_wait("t3_tick_c");
      tick_wait("t3_tick_d");
`ifdef DAC_FEEDER_INTERP_EN
      e = '{-32768, -32768, -16385, -1, 16383, 32767, 32767};
`else
      e = '{-32768, 32767, 32767, 32767, 32767, 32767, 32767};
`endif
      chk_seq("t3_full_scale", e);

      @(posedge clk); #1;
      s_valid = 1; s_data = 1; accs = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         a = int'(s_ready);
         accs += a;
         if (i == 4) begin
            check("t4_level_full", int'(fifo_level), 4);
            check("t4_ready_low", int'(s_ready), 0);
         end
         if (i == 8 || i == 24 || i == 40) check($sformatf("t4_accepts_%0d", i), accs, 4 + i / 16);
         @(posedge clk); #1;
         if (a != 0) s_data = s_data + 16'd1;
      end
      s_valid = 0;
      check("t4_accepts_total", accs, 7);

      push(1000);
      for (int i = 0; i < 8; i++) begin
         tick_wait("t5_drain_tick");
         if (fifo_level == 0) break;
      end
      check("t5_uf_pulse", int'(underflow), 1);
      check("t5_hold", $signed(sample_out), 1000);
      @(negedge clk);
      check("t5_uf_one_cycle", int'(underflow), 0);
      repeat (15) @(posedge clk);
      #1 s_valid = 1; s_data = 16'd2000;
      @(negedge clk);
      check("t5_tick2", int'(sample_tick), 1);
      check("t5_uf2", int'(underflow), 1);
      check("t5_ready2", int'(s_ready), 1);
      @(posedge clk); #1 s_valid = 0;
      @(negedge clk);
      check("t5_level_after_tick_push", int'(fifo_level), 1);
      check("t5_hold2", $signed(sample_out), 1000);
      tick_wait("t5_tick3");
      check("t5_no_uf3", int'(underflow), 0);
      check("t5_hold3", $signed(sample_out), 1000);
      check("t5_level3", int'(fifo_level), 1);

      push(3000); push(4000);
      tick_wait("t6_tick");
      repeat (3) @(posedge clk);
      #1;
`ifdef DAC_FEEDER_INTERP_EN
      check("t6_pre_out", $signed(sample_out), 2250);
`else
      check("t6_pre_out", $signed(sample_out), 3000);
`endif
      check("t6_pre_level", int'(fifo_level), 1);
      rst = 1;
      #1 chk_reset("t6_rst");
      check("t6_rst_tick", int'(sample_tick), 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      tick_wait("t6_post_tick");
      check("t6_post_uf", int'(underflow), 1);
      check("t6_post_out", $signed(sample_out), 0);
      check("t6_post_level", int'(fifo_level), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
